hilo_div_seq: RTL and testbench
===============================

Name: hilo_div_seq

Overview:
Multi-cycle iterative divider in the EX stage. It is the producer side of the HI/LO register pair: it computes the quotient, destined for LO, and the remainder, destined for HI. The result is presented as one 64-bit word, which the EX stage converts into the hi/lo write-enable and data that travel down MEM/WB. While a division is in progress, the block requests a pipeline stall and it accepts a flush/annul.

Parameters:
WIDTH, 32, operand width; result is 2*WIDTH bits {remainder, quotient}
CNT_W, 6, iteration counter width; must hold the value WIDTH

Ports:
clk  input  1  clock, rising-edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
signed_div_i  input  1  1 = signed (div), 0 = unsigned (divu); sampled with start_i
opdata1_i  input  WIDTH  dividend; sampled when a start is accepted
opdata2_i  input  WIDTH  divisor; sampled when a start is accepted
start_i  input  1  level request from EX; held high until ready_o is seen
annul_i  input  1  flush; abort the current division
result_o  output  2*WIDTH  [2W-1:W] = remainder (HI), [W-1:0] = quotient (LO)
ready_o  output  1  result_o valid
stall_req_o  output  1  high while start_i=1 and ready_o=0

Behaviour:
- Reset (rst=0, asynchronous, no clock needed): state=FREE, cnt=0, result_o=0, ready_o=0, internal dividend/divisor/partial-remainder registers=0.
- States: FREE, BY_ZERO, ON, END. All outputs are registered except stall_req_o, which is combinational: start_i & ~ready_o.
- FREE:
  - If start_i=1 and annul_i=0 and opdata2_i==0: go to BY_ZERO.
  - If start_i=1 and annul_i=0 and opdata2_i!=0: go to ON, cnt=0, latch |dividend| and |divisor| (absolute values only when signed_div_i=1), and latch both operand signs and signed_div_i.
  - Otherwise: remain in FREE with ready_o=0 and result_o=0.
- BY_ZERO: on the next edge go to END with result_o=0.
- ON, annul_i=0, cnt<WIDTH: one restoring-division step per edge.
  - Shift {partial remainder, dividend} left by 1.
  - Trial subtract the divisor, using a WIDTH+1-bit subtract.
  - If the result is non-negative, keep the difference and shift in quotient bit 1; otherwise shift in 0.
  - cnt++.
- ON, annul_i=0, cnt==WIDTH:
  - If signed, negate the quotient when the dividend sign differs from the divisor sign.
  - If signed, negate the remainder when the dividend is negative (the remainder takes the dividend's sign).
  - Load result_o, set ready_o=1, go to END.
- ON, annul_i=1 (any cnt): go to FREE on that edge with ready_o=0 and cnt=0. Annul has priority over iteration and completion.
- END:
  - result_o and ready_o are held.
  - When start_i=0, go to FREE with ready_o=0 and result_o=0.
  - annul_i=1 also forces FREE.
- Latency: start accepted at edge E0; iterations at E1..E32; ready_o=1 after E33, i.e. 33 cycles for WIDTH=32. Divide-by-zero takes 2 cycles.
- Overflow case -2^W-1 / -1 (signed): quotient = 0x80000000, remainder = 0. This is not an exception and is produced naturally by the algorithm.
- A new start is not accepted while in ON, BY_ZERO or END. Operand changes during ON are ignored.
- start_i and annul_i both high in FREE: the start is not accepted.

Test Plan:
- Unsigned 100/7: start_i=1, signed=0 -> stall_req_o=1 for 33 cycles; then ready_o=1, result_o[31:0]=14, result_o[63:32]=2; drop start_i -> next cycle ready_o=0.
- Signed -7/2 (0xFFFFFFF9 / 0x00000002) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Also run 7/-2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
- Divide by zero: opdata2_i=0 -> ready_o=1 two cycles after start, result_o=0.
- Annul mid-op: assert annul_i for 1 cycle at iteration 10 -> state FREE, ready_o never rises. A new start of 0xFFFFFFFF/0x10 unsigned issued next cycle completes after 33 cycles with quotient 0x0FFFFFFF, remainder 0xF.
- Overflow: signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0x00000000.
- Async reset: drive rst=0 between clock edges at iteration 20 -> result_o=0 and ready_o=0 immediately; after release the block starts in FREE and accepts a new start.

Source files
------------

// File: rtl/hilo_div_seq_if.sv
// EX-stage <-> HI/LO divider handshake: operands and start/annul in, result/ready/stall out.
interface hilo_div_seq_if #(
  parameter int WIDTH = 32
);
  logic                 signed_div_i;
  logic [WIDTH-1:0]     opdata1_i;
  logic [WIDTH-1:0]     opdata2_i;
  logic                 start_i;
  logic                 annul_i;
  logic [2*WIDTH-1:0]   result_o;
  logic                 ready_o;
  logic                 stall_req_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, stall_req_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, stall_req_o
  );
endinterface

// File: rtl/hilo_div_seq.sv
// Iterative restoring divider producing {remainder (HI), quotient (LO)} for the EX stage.
// One quotient bit per cycle on operand magnitudes; signs are applied on completion.
module hilo_div_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic           clk,
  input  logic           rst,
  hilo_div_seq_if.slave  bus
);

  typedef enum logic [1:0] {FREE, BY_ZERO, ON, END} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [WIDTH-1:0]     dvd, dvd_nxt;
  logic [WIDTH-1:0]     dvs, dvs_nxt;
  logic [WIDTH-1:0]     rem, rem_nxt;
  logic                 sign_a, sign_a_nxt;
  logic                 sign_b, sign_b_nxt;
  logic                 is_signed, is_signed_nxt;
  logic [2*WIDTH-1:0]   result, result_nxt;
  logic                 ready, ready_nxt;

  logic [WIDTH-1:0]     abs_a, abs_b;
  logic [WIDTH:0]       shifted, diff;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  assign abs_a = (bus.signed_div_i && bus.opdata1_i[WIDTH-1]) ? -bus.opdata1_i : bus.opdata1_i;
  assign abs_b = (bus.signed_div_i && bus.opdata2_i[WIDTH-1]) ? -bus.opdata2_i : bus.opdata2_i;

  // Partial remainder stays below the divisor, so the W+1-bit difference never overflows
  // and its top bit is a valid sign.
  assign shifted = {rem, dvd[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs};

  assign quo_fix = (is_signed && (sign_a ^ sign_b)) ? -dvd : dvd;
  assign rem_fix = (is_signed && sign_a) ? -rem : rem;

  assign bus.result_o    = result;
  assign bus.ready_o     = ready;
  assign bus.stall_req_o = bus.start_i & ~ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= FREE;
      cnt       <= '0;
      dvd       <= '0;
      dvs       <= '0;
      rem       <= '0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      is_signed <= 1'b0;
      result    <= '0;
      ready     <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      dvd       <= dvd_nxt;
      dvs       <= dvs_nxt;
      rem       <= rem_nxt;
      sign_a    <= sign_a_nxt;
      sign_b    <= sign_b_nxt;
      is_signed <= is_signed_nxt;
      result    <= result_nxt;
      ready     <= ready_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    dvd_nxt       = dvd;
    dvs_nxt       = dvs;
    rem_nxt       = rem;
    sign_a_nxt    = sign_a;
    sign_b_nxt    = sign_b;
    is_signed_nxt = is_signed;
    result_nxt    = result;
    ready_nxt     = ready;

    case (state)
      FREE: begin
        ready_nxt  = 1'b0;
        result_nxt = '0;
        if (bus.start_i && !bus.annul_i) begin
          if (bus.opdata2_i == '0) begin
            state_nxt = BY_ZERO;
          end else begin
            state_nxt     = ON;
            cnt_nxt       = '0;
            dvd_nxt       = abs_a;
            dvs_nxt       = abs_b;
            rem_nxt       = '0;
            sign_a_nxt    = bus.opdata1_i[WIDTH-1];
            sign_b_nxt    = bus.opdata2_i[WIDTH-1];
            is_signed_nxt = bus.signed_div_i;
          end
        end
      end

      BY_ZERO: begin
        state_nxt  = END;
        result_nxt = '0;
        ready_nxt  = 1'b1;
      end

      // Annul wins over both iteration and completion.
      ON: begin
        if (bus.annul_i) begin
          state_nxt = FREE;
          ready_nxt = 1'b0;
          cnt_nxt   = '0;
        end else if (cnt != LAST) begin
          rem_nxt = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
          dvd_nxt = {dvd[WIDTH-2:0], ~diff[WIDTH]};
          cnt_nxt = cnt + 1'b1;
        end else begin
          result_nxt = {rem_fix, quo_fix};
          ready_nxt  = 1'b1;
          state_nxt  = END;
        end
      end

      END: begin
        if (bus.annul_i || !bus.start_i) begin
          state_nxt  = FREE;
          ready_nxt  = 1'b0;
          result_nxt = '0;
        end
      end

      default: state_nxt = FREE;
    endcase
  end

endmodule

// File: tb/tb_hilo_div_seq.sv
// Scoreboard bench for hilo_div_seq: directed divisions queue expected results,
// a negedge monitor compares them when ready_o rises.
module tb_hilo_div_seq;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hilo_div_seq_if #(.WIDTH(W)) bus();

  hilo_div_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [63:0] res;
    int          startCyc;
    int          lat;
  } exp_t;

  exp_t sbq[$];
  exp_t monExp;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic readyPrev = 1'b0;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Each rising edge of ready_o must correspond to exactly one queued division.
  always @(negedge clk) begin
    if (bus.ready_o && !readyPrev) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_ready: got result 0x%0h with nothing outstanding", bus.result_o);
      end else begin
        monExp = sbq.pop_front();
        checkOutput("result", bus.result_o, monExp.res);
        checkOutput("latency", 64'(cyc - monExp.startCyc), 64'(monExp.lat));
      end
    end
    readyPrev = bus.ready_o;
  end

  task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                               input logic [63:0] expRes, input int expLat, input int expStall);
    exp_t e;
    int   stallCnt;
    bit   seen;
    @(negedge clk);
    e.res = expRes;
    e.startCyc = cyc;
    e.lat = expLat;
    sbq.push_back(e);
    bus.signed_div_i = sgn;
    bus.opdata1_i = a;
    bus.opdata2_i = b;
    bus.start_i = 1'b1;
    stallCnt = 0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (bus.ready_o) seen = 1'b1;
      else if (bus.stall_req_o) stallCnt++;
      bus.opdata1_i = ~a;
      bus.opdata2_i = b ^ 32'h5;
      bus.signed_div_i = ~sgn;
    end
    checkOutput("ready_seen", 64'(seen), 64'd1);
    checkOutput("stall_cycles", 64'(stallCnt), 64'(expStall));
    checkOutput("stall_while_ready", 64'(bus.stall_req_o), 64'd0);
    bus.start_i = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_drop", 64'(bus.ready_o), 64'd0);
    checkOutput("result_after_drop", bus.result_o, 64'd0);
  endtask

  initial begin
    bit sawReady;
    bit seen;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i = '0;
    bus.opdata2_i = '0;
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    #1;
    checkOutput("reset_result", bus.result_o, 64'd0);
    checkOutput("reset_ready", 64'(bus.ready_o), 64'd0);
    checkOutput("reset_stall", 64'(bus.stall_req_o), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    applyStimulus(1'b0, 32'd100,       32'd7,        {32'd2,        32'd14},       34, 33);
    applyStimulus(1'b1, 32'hFFFFFFF9,  32'h00000002, {32'hFFFFFFFF, 32'hFFFFFFFD}, 34, 33);
    applyStimulus(1'b1, 32'h00000007,  32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD}, 34, 33);
    applyStimulus(1'b0, 32'd5,         32'd0,        64'd0,                         2,  1);
    applyStimulus(1'b1, 32'h80000000,  32'hFFFFFFFF, {32'h00000000, 32'h80000000}, 34, 33);
    applyStimulus(1'b0, 32'h80000000,  32'd3,        {32'h00000002, 32'h2AAAAAAA}, 34, 33);
    applyStimulus(1'b1, 32'h80000000,  32'd3,        {32'hFFFFFFFE, 32'hD5555556}, 34, 33);
    applyStimulus(1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9, {32'hFFFFFFFE, 32'h0000000E}, 34, 33);
    applyStimulus(1'b0, 32'd5,         32'd10,       {32'd5,        32'd0},        34, 33);
    applyStimulus(1'b1, 32'd0,         32'd0,        64'd0,                         2,  1);

    // Annul at iteration 10; nothing may complete afterwards.
    @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i = 32'd100;
    bus.opdata2_i = 32'd7;
    bus.start_i = 1'b1;
    sawReady = 1'b0;
    repeat (11) begin
      @(negedge clk);
      sawReady |= bus.ready_o;
    end
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    @(negedge clk);
    bus.annul_i = 1'b0;
    repeat (30) begin
      @(negedge clk);
      sawReady |= bus.ready_o;
    end
    checkOutput("annul_no_ready", 64'(sawReady), 64'd0);
    applyStimulus(1'b0, 32'hFFFFFFFF, 32'h00000010, {32'h0000000F, 32'h0FFFFFFF}, 34, 33);

    // Asynchronous reset at iteration 20, between clock edges.
    @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i = 32'd1000;
    bus.opdata2_i = 32'd3;
    bus.start_i = 1'b1;
    repeat (21) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("async_rst_mid_ready", 64'(bus.ready_o), 64'd0);
    checkOutput("async_rst_mid_result", bus.result_o, 64'd0);
    bus.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, {32'h00000000, 32'h00000001}, 34, 33);

    // Asynchronous reset while a finished result is being held.
    @(negedge clk);
    sbq.push_back('{res: {32'd1, 32'd4}, startCyc: cyc, lat: 34});
    bus.signed_div_i = 1'b0;
    bus.opdata1_i = 32'd9;
    bus.opdata2_i = 32'd2;
    bus.start_i = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (bus.ready_o) seen = 1'b1;
    end
    checkOutput("end_ready_seen", 64'(seen), 64'd1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("async_rst_end_ready", 64'(bus.ready_o), 64'd0);
    checkOutput("async_rst_end_result", bus.result_o, 64'd0);
    bus.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    checkOutput("scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

endmodule
